// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL lock sequencer: state encodings, default
// widths and gains, and the saturating magnitude helper.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COARSE   = 3'd1,
        ST_FINE     = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_HOLDOVER = 3'd4
    } lock_state_t;

    localparam int ERR_W_DEF     = 8;
    localparam int GAIN_W_DEF    = 4;
    localparam int KP_COARSE_DEF = 2;
    localparam int KP_FINE_DEF   = 6;

    // Two's-complement magnitude of a w-bit value; the most negative code
    // clamps to the largest positive code so the result still fits in w bits.
    function automatic int abs_sat(input int x, input int w);
        int mag;
        int lim;
        mag = (x < 0) ? -x : x;
        lim = (1 << (w - 1)) - 1;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/adpll_err_window.sv
// Combinational phase-error classifier: saturated |err| compared against the
// lock window and the coarse re-acquisition threshold.
module adpll_err_window
    import adpll_pkg::*;
#(
    parameter int ERR_W         = ERR_W_DEF,
    parameter int LOCK_THRESH   = 4,
    parameter int COARSE_THRESH = 64
) (
    input  logic signed [ERR_W-1:0] phase_err,
    output logic                    in_window,
    output logic                    coarse_trip
);

    int err_mag;

    assign err_mag     = abs_sat(int'(phase_err), ERR_W);
    assign in_window   = (err_mag < LOCK_THRESH);
    assign coarse_trip = (err_mag >= COARSE_THRESH);

endmodule

// File: rtl/adpll_lock_ctrl.sv
// ADPLL acquisition/lock sequencer: gain selection, DCO hold and lock report.
// Define ADPLL_LOCK_STATS_EN to add the loss_count and acq_cycles statistics.
module adpll_lock_ctrl
    import adpll_pkg::*;
#(
    parameter int ERR_W         = ERR_W_DEF,
    parameter int GAIN_W        = GAIN_W_DEF,
    parameter int KP_COARSE     = KP_COARSE_DEF,
    parameter int KP_FINE       = KP_FINE_DEF,
    parameter int LOCK_THRESH   = 4,
    parameter int COARSE_THRESH = 64,
    parameter int SETTLE_CNT    = 32,
    parameter int LOCK_CNT      = 16,
    parameter int UNLOCK_CNT    = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [ERR_W-1:0] phase_err,
    input  logic                    phase_err_valid,
    output logic [GAIN_W-1:0]       loop_gain_shift,
    output logic                    coarse_mode,
    output logic                    dco_hold,
    output logic                    locked,
    output logic                    lock_lost,
    output logic [2:0]              state
`ifdef ADPLL_LOCK_STATS_EN
    ,
    output logic [15:0]             loss_count,
    output logic [15:0]             acq_cycles
`endif
);

    localparam int SET_W = $clog2(SETTLE_CNT + 1);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);
    localparam int ULK_W = $clog2(UNLOCK_CNT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    lock_state_t       state_q, next_state;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              coarse_q, coarse_d;
    logic              hold_q, hold_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;

    logic [SET_W-1:0]  settle_cnt;
    logic [LCK_W-1:0]  inwin_cnt;
    logic [ULK_W-1:0]  outwin_cnt;
    logic [WD_W-1:0]   wd_cnt;

    logic              in_window;
    logic              coarse_trip;
    logic              wd_expire;
    logic              state_chg;

    adpll_err_window #(
        .ERR_W        (ERR_W),
        .LOCK_THRESH  (LOCK_THRESH),
        .COARSE_THRESH(COARSE_THRESH)
    ) u_err_window (
        .phase_err  (phase_err),
        .in_window  (in_window),
        .coarse_trip(coarse_trip)
    );

    // Expires on the TIMEOUT-th consecutive cycle without a valid sample.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1)) && !phase_err_valid;
    assign state_chg = (next_state != state_q);

    // NOTE: every register in this design, state and outputs alike, is cleared
    // by the synchronous reset so a mid-run reset matches power-up exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gain_q   <= GAIN_W'(KP_COARSE);
            coarse_q <= 1'b0;
            hold_q   <= 1'b1;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers see pre-edge values regardless of statement order.
            state_q  <= next_state;
            gain_q   <= gain_d;
            coarse_q <= coarse_d;
            hold_q   <= hold_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        // NOTE: defaulting next_state before the case keeps this block free of
        // inferred latches on paths that do not assign it.
        next_state = state_q;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: next_state = ST_COARSE;
                ST_COARSE: begin
                    if (phase_err_valid) begin
                        if (settle_cnt == SET_W'(SETTLE_CNT - 1)) next_state = ST_FINE;
                    end else if (wd_expire) begin
                        next_state = ST_HOLDOVER;
                    end
                end
                ST_FINE: begin
                    if (phase_err_valid) begin
                        if (coarse_trip)
                            next_state = ST_COARSE;
                        else if (in_window && inwin_cnt == LCK_W'(LOCK_CNT - 1))
                            next_state = ST_LOCKED;
                    end else if (wd_expire) begin
                        next_state = ST_HOLDOVER;
                    end
                end
                ST_LOCKED: begin
                    if (phase_err_valid) begin
                        if (coarse_trip)
                            next_state = ST_COARSE;
                        else if (!in_window && outwin_cnt == ULK_W'(UNLOCK_CNT - 1))
                            next_state = ST_FINE;
                    end else if (wd_expire) begin
                        next_state = ST_HOLDOVER;
                    end
                end
                ST_HOLDOVER: begin
                    if (phase_err_valid) next_state = ST_FINE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, decoded from the state being entered.
    always_comb begin
        gain_d   = gain_q;
        coarse_d = 1'b0;
        hold_d   = 1'b0;
        locked_d = 1'b0;
        lost_d   = enable && (state_q == ST_LOCKED) && (next_state != ST_LOCKED);
        unique case (next_state)
            ST_IDLE: begin
                gain_d = GAIN_W'(KP_COARSE);
                hold_d = 1'b1;
            end
            ST_COARSE: begin
                gain_d   = GAIN_W'(KP_COARSE);
                coarse_d = 1'b1;
            end
            ST_FINE:     gain_d = GAIN_W'(KP_FINE);
            ST_LOCKED: begin
                gain_d   = GAIN_W'(KP_FINE);
                locked_d = 1'b1;
            end
            ST_HOLDOVER: hold_d = 1'b1;
            default:     hold_d = 1'b1;
        endcase
    end

    // Sample counters and watchdog; all restart on any state change.
    always_ff @(posedge clk) begin
        if (reset || state_chg) begin
            settle_cnt <= '0;
            inwin_cnt  <= '0;
            outwin_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            if (phase_err_valid)
                wd_cnt <= '0;
            else if (!(&wd_cnt))
                wd_cnt <= wd_cnt + 1'b1;

            if (phase_err_valid) begin
                unique case (state_q)
                    ST_COARSE: if (!(&settle_cnt)) settle_cnt <= settle_cnt + 1'b1;
                    ST_FINE: begin
                        if (!in_window)
                            inwin_cnt <= '0;
                        else if (!(&inwin_cnt))
                            inwin_cnt <= inwin_cnt + 1'b1;
                    end
                    ST_LOCKED: begin
                        if (in_window)
                            outwin_cnt <= '0;
                        else if (!(&outwin_cnt))
                            outwin_cnt <= outwin_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ADPLL_LOCK_STATS_EN
    logic [15:0] loss_q;
    logic [15:0] acq_timer;
    logic [15:0] acq_q;

    // acq_timer runs from the most recent COARSE entry and is latched on LOCKED entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            loss_q    <= '0;
            acq_timer <= '0;
            acq_q     <= '0;
        end else begin
            if (lost_d && !(&loss_q)) loss_q <= loss_q + 1'b1;

            if (next_state == ST_COARSE && state_q != ST_COARSE)
                acq_timer <= '0;
            else if (!(&acq_timer))
                acq_timer <= acq_timer + 1'b1;

            if (next_state == ST_LOCKED && state_q != ST_LOCKED)
                acq_q <= (&acq_timer) ? acq_timer : acq_timer + 1'b1;
        end
    end

    assign loss_count = loss_q;
    assign acq_cycles = acq_q;
`endif

    assign state           = state_q;
    assign loop_gain_shift = gain_q;
    assign coarse_mode     = coarse_q;
    assign dco_hold        = hold_q;
    assign locked          = locked_q;
    assign lock_lost       = lost_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Self-checking bench for adpll_lock_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a behavioural model.
module tb_adpll_lock_ctrl;

    logic              clk;
    logic              reset;
    logic              enable;
    logic signed [7:0] phase_err;
    logic              phase_err_valid;
    logic [3:0]        loop_gain_shift;
    logic              coarse_mode;
    logic              dco_hold;
    logic              locked;
    logic              lock_lost;
    logic [2:0]        state;
`ifdef ADPLL_LOCK_STATS_EN
    logic [15:0]       loss_count;
    logic [15:0]       acq_cycles;
`endif

    int checks;
    int failures;

    adpll_lock_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .phase_err      (phase_err),
        .phase_err_valid(phase_err_valid),
        .loop_gain_shift(loop_gain_shift),
        .coarse_mode    (coarse_mode),
        .dco_hold       (dco_hold),
        .locked         (locked),
        .lock_lost      (lock_lost),
        .state          (state)
`ifdef ADPLL_LOCK_STATS_EN
        ,
        .loss_count     (loss_count),
        .acq_cycles     (acq_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the sequencer in terms of samples seen since
    // entering a mode, the current good/bad run length and the quiet time.
    int m_state, m_gain, m_lost, m_samp, m_run, m_bad, m_quiet;
    bit model_ready = 1'b0;

    always @(posedge clk) begin
        int e, mag, nxt;
        if (reset) begin
            m_state = 0; m_gain = 2; m_lost = 0;
            m_samp = 0; m_run = 0; m_bad = 0; m_quiet = 0;
            model_ready = 1'b1;
        end else begin
            e   = int'(phase_err);
            mag = (e < 0) ? -e : e;
            if (mag > 127) mag = 127;
            nxt    = m_state;
            m_lost = 0;
            if (!enable) begin
                nxt = 0;
            end else if (m_state == 0) begin
                nxt = 1;
            end else if (m_state == 4) begin
                if (phase_err_valid) nxt = 2;
            end else if (phase_err_valid) begin
                m_quiet = 0;
                if (m_state == 1) begin
                    m_samp++;
                    if (m_samp >= 32) nxt = 2;
                end else if (mag >= 64) begin
                    nxt = 1;
                end else if (m_state == 2) begin
                    if (mag < 4) m_run++; else m_run = 0;
                    if (m_run >= 16) nxt = 3;
                end else begin
                    if (mag >= 4) m_bad++; else m_bad = 0;
                    if (m_bad >= 4) nxt = 2;
                end
            end else begin
                m_quiet++;
                if (m_quiet >= 1024) nxt = 4;
            end
            if (m_state == 3 && nxt != 3 && enable) m_lost = 1;
            if (nxt != m_state) begin
                m_samp = 0; m_run = 0; m_bad = 0; m_quiet = 0;
            end
            m_state = nxt;
            if (m_state == 0 || m_state == 1) m_gain = 2;
            else if (m_state == 2 || m_state == 3) m_gain = 6;
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("cmp_state",  32'(state),           m_state);
            check("cmp_gain",   32'(loop_gain_shift), m_gain);
            check("cmp_coarse", 32'(coarse_mode),     (m_state == 1) ? 1 : 0);
            check("cmp_hold",   32'(dco_hold),        (m_state == 0 || m_state == 4) ? 1 : 0);
            check("cmp_locked", 32'(locked),          (m_state == 3) ? 1 : 0);
            check("cmp_lost",   32'(lock_lost),       m_lost);
        end
    end

    // Each step applies inputs at a falling edge; on return the outputs reflect them.
    task automatic step(input logic en, input logic v, input int e);
        enable          = en;
        phase_err_valid = v;
        phase_err       = 8'(e);
        @(negedge clk);
    endtask

    task automatic istep();
        step(1'b1, 1'b0, 0);
    endtask

    task automatic vstep(input int e);
        step(1'b1, 1'b1, e);
    endtask

    // n valid samples one reference period apart; returns right after the last.
    task automatic burst(input int n, input int e);
        for (int i = 0; i < n; i++) begin
            if (i > 0) istep();
            vstep(e);
        end
    endtask

    int silences;

    initial begin
        int mode, len, v;
        checks = 0;
        failures = 0;
        silences = 0;
        reset = 1'b1; enable = 1'b1; phase_err_valid = 1'b0; phase_err = '0;
        repeat (3) @(negedge clk);

        // Reset state, then entry into COARSE.
        check("rst_state", 32'(state), 0);
        check("rst_gain", 32'(loop_gain_shift), 2);
        check("rst_hold", 32'(dco_hold), 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_lost", 32'(lock_lost), 0);
        check("rst_coarse", 32'(coarse_mode), 0);
        reset = 1'b0;
        istep();
        check("t1_state", 32'(state), 1);
        check("t1_hold", 32'(dco_hold), 0);
        check("t1_gain", 32'(loop_gain_shift), 2);

        // Settle then lock.
        burst(31, 50);
        check("t2_settle31", 32'(state), 1);
        istep(); vstep(50);
        check("t2_fine", 32'(state), 2);
        check("t2_gain", 32'(loop_gain_shift), 6);
        burst(15, 3);
        istep();
        check("t2_not_yet", 32'(locked), 0);
        vstep(3);
        check("t2_locked", 32'(locked), 1);
        check("t2_model", 32'(m_state), 3);

        // Interrupted bad runs keep lock; four consecutive drop it.
        istep(); burst(3, -10); istep(); vstep(3); istep(); burst(3, -10);
        check("t3_hold_lock", 32'(locked), 1);
        istep(); vstep(-10);
        check("t3_lost", 32'(lock_lost), 1);
        check("t3_state", 32'(state), 2);
        check("t3_locked", 32'(locked), 0);
        istep();
        check("t3_pulse1", 32'(lock_lost), 0);

        // Most negative error saturates and trips coarse.
        istep(); burst(16, 3);
        check("t4_relock", 32'(state), 3);
        istep(); vstep(-128);
        check("t4_state", 32'(state), 1);
        check("t4_gain", 32'(loop_gain_shift), 2);
        check("t4_lost", 32'(lock_lost), 1);

        // Watchdog from FINE; the sample that leaves HOLDOVER is not evaluated.
        istep(); burst(32, 50);
        check("t5_fine", 32'(state), 2);
        repeat (1023) istep();
        check("t5_before", 32'(state), 2);
        istep();
        check("t5_holdover", 32'(state), 4);
        check("t5_hold", 32'(dco_hold), 1);
        check("t5_gain", 32'(loop_gain_shift), 6);
        check("t5_model", 32'(m_state), 4);
        istep(); vstep(100);
        check("t5_back", 32'(state), 2);
        check("t5_unhold", 32'(dco_hold), 0);

        // Watchdog from LOCKED pulses lock_lost.
        istep(); burst(16, 3);
        check("t5b_locked", 32'(locked), 1);
        repeat (1023) istep();
        check("t5b_before", 32'(lock_lost), 0);
        istep();
        check("t5b_state", 32'(state), 4);
        check("t5b_lost", 32'(lock_lost), 1);
        check("t5b_locked0", 32'(locked), 0);
        vstep(2);

        // Disable during LOCKED: silent return to IDLE.
        istep(); burst(16, 3);
        check("t6_locked", 32'(state), 3);
        step(1'b0, 1'b0, 0);
        check("t6_state", 32'(state), 0);
        check("t6_locked0", 32'(locked), 0);
        check("t6_nolost", 32'(lock_lost), 0);
        check("t6_hold", 32'(dco_hold), 1);

        // Reset mid-acquisition.
        istep(); burst(5, 50);
        reset = 1'b1;
        istep();
        reset = 1'b0;
        check("t7_state", 32'(state), 0);
        check("t7_gain", 32'(loop_gain_shift), 2);
        check("t7_hold", 32'(dco_hold), 1);
        istep();
        check("t7_coarse", 32'(state), 1);

        // Randomized traffic, checked each cycle against the model.
        for (int seg = 0; seg < 40; seg++) begin
            mode = int'($urandom_range(0, 6));
            if (mode == 3 && silences >= 4) mode = 0;
            case (mode)
                0: for (int i = 0; i < 120; i++) begin
                       v = int'($urandom_range(0, 6)) - 3;
                       step(1'b1, $urandom_range(0, 1) == 0, v);
                   end
                1: for (int i = 0; i < 100; i++)
                       step(1'b1, $urandom_range(0, 2) == 0, int'($urandom_range(0, 255)));
                2: for (int i = 0; i < 80; i++) begin
                       case ($urandom_range(0, 9))
                           0: v = -64;  1: v = -63;  2: v = 63;  3: v = 64;
                           4: v = -4;   5: v = 4;    6: v = -3;  7: v = 3;
                           8: v = -128; default: v = 127;
                       endcase
                       if ($urandom_range(0, 3) != 0) v = int'($urandom_range(0, 4)) - 2;
                       step(1'b1, $urandom_range(0, 1) == 0, v);
                   end
                3: begin
                       silences++;
                       len = int'($urandom_range(1000, 1050));
                       repeat (len) istep();
                   end
                4: begin
                       len = int'($urandom_range(1, 4));
                       repeat (len) step(1'b0, $urandom_range(0, 1) == 0, 1);
                   end
                5: for (int i = 0; i < 70; i++) step(1'b1, (i % 2) == 0, 20);
                default: begin
                       reset = 1'b1;
                       repeat (2) istep();
                       reset = 1'b0;
                   end
            endcase
        end
        istep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
